// File: rtl/updi_pkg.sv
// ---------------------------------------------------------------------------
// updi_pkg
// Shared types for the UPDI response queue handler:
//   updi_response_queue_handler_state : the response FSM states
//   updi_resp_error_t                 : the error_code encoding
//   UPDI_ACK_BYTE                     : the byte value a target sends as an ACK
// ---------------------------------------------------------------------------
package updi_pkg;

    localparam logic [7:0] UPDI_ACK_BYTE = 8'h40;

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_WAIT,
        CAPTURE,
        DONE
    } updi_response_queue_handler_state;

    typedef enum logic [1:0] {
        NONE    = 2'd0,
        BAD_ACK = 2'd1,
        TIMEOUT = 2'd2
    } updi_resp_error_t;

endpackage

// File: rtl/updi_response_queue_handler_if.sv
// ---------------------------------------------------------------------------
// updi_response_queue_handler_if
// Bundles the request/status handshake and the RX FIFO read port.
//   Request : start, rx_len, ack_expect           (controller -> handler)
//   Status  : ready, done, ack_received,
//             error_code, data, data_count        (handler -> controller)
//   FIFO    : fifo_data, fifo_empty (in), fifo_rd_en (out)
// modport slave  : the handler side
// modport master : the controller / FIFO side
// ---------------------------------------------------------------------------
interface updi_response_queue_handler_if #(
    parameter int MAX_DATA_SIZE  = 16,
    parameter int DATA_ADDR_BITS = $clog2(MAX_DATA_SIZE)
) ();
    logic                               start;
    logic [DATA_ADDR_BITS:0]            rx_len;
    logic [MAX_DATA_SIZE-1:0]           ack_expect;
    logic                               ready;
    logic                               done;
    logic                               ack_received;
    logic [1:0]                         error_code;
    logic [MAX_DATA_SIZE-1:0][7:0]      data;
    logic [DATA_ADDR_BITS:0]            data_count;
    logic [7:0]                         fifo_data;
    logic                               fifo_rd_en;
    logic                               fifo_empty;

    modport slave (
        input  start, rx_len, ack_expect, fifo_data, fifo_empty,
        output ready, done, ack_received, error_code, data, data_count, fifo_rd_en
    );

    modport master (
        output start, rx_len, ack_expect, fifo_data, fifo_empty,
        input  ready, done, ack_received, error_code, data, data_count, fifo_rd_en
    );
endinterface

// File: rtl/updi_response_queue_handler_timeout_counter.sv
// ---------------------------------------------------------------------------
// updi_timeout_counter
// Idle-cycle counter for the response handler's timeout option.
//   clk, rst_n : clock, async active-low reset
//   clear      : synchronous clear (has priority over enable)
//   enable     : count this cycle
//   expired    : count has reached TIMEOUT_CYCLES-1 while enabled
// ---------------------------------------------------------------------------
module updi_timeout_counter #(
    parameter int TIMEOUT_CYCLES = 65536
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] r_cnt;

    assign expired = enable && (r_cnt == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (clear) begin
            r_cnt <= '0;
        end else if (enable && !expired) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end
endmodule

// File: rtl/updi_response_queue_handler.sv
// ---------------------------------------------------------------------------
// updi_response_queue_handler
// RX-side companion to the UPDI instruction queue handler. Pops response
// bytes from an external RX FIFO, checks expected ACK bytes (0x40), pulses
// ack_received for each good ACK, packs data bytes into a buffer and reports
// done / error_code per response.
//   clk, rst_n : clock, async active-low reset
//   bus        : updi_response_queue_handler_if.slave (request, status, FIFO)
// Optional feature: define UPDI_RESP_TIMEOUT_EN to abort a response with
// error_code=2 after TIMEOUT_CYCLES idle cycles waiting on an empty FIFO.
// ---------------------------------------------------------------------------
module updi_response_queue_handler
    import updi_pkg::*;
#(
    parameter int MAX_DATA_SIZE  = 16,
    parameter int DATA_ADDR_BITS = $clog2(MAX_DATA_SIZE),
    parameter int TIMEOUT_CYCLES = 65536
) (
    input  logic                            clk,
    input  logic                            rst_n,
    updi_response_queue_handler_if.slave    bus
);
    localparam int LEN_W = DATA_ADDR_BITS + 1;
    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_DATA_SIZE);

    updi_response_queue_handler_state   r_state, w_state_nxt;
    updi_resp_error_t                   r_err, w_err_nxt;
    logic [LEN_W-1:0]                   r_len, w_len_nxt;
    logic [MAX_DATA_SIZE-1:0]           r_ack_exp, w_ack_exp_nxt;
    logic [DATA_ADDR_BITS-1:0]          r_idx, w_idx_nxt;
    logic [LEN_W-1:0]                   r_count, w_count_nxt;
    logic [MAX_DATA_SIZE-1:0][7:0]      r_data, w_data_nxt;
    logic                               r_ready, w_ready_nxt;
    logic                               r_done, w_done_nxt;
    logic                               r_ack, w_ack_nxt;
    logic                               r_rd_en, w_rd_en_nxt;
    logic [LEN_W-1:0]                   w_len_clamp;
    logic                               w_last;
    logic                               w_expired;

    assign w_len_clamp = (bus.rx_len > MAX_LEN) ? MAX_LEN : bus.rx_len;
    assign w_last      = ({1'b0, r_idx} == (r_len - LEN_W'(1)));

`ifdef UPDI_RESP_TIMEOUT_EN
    // Counter is held clear outside a response and restarts on every read,
    // so it only measures consecutive starved cycles in RD_REQ.
    updi_timeout_counter #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (r_rd_en || (r_state == IDLE)),
        .enable  ((r_state == RD_REQ) && bus.fifo_empty),
        .expired (w_expired)
    );
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
    assign w_expired = 1'b0;
`endif

    always_comb begin
        w_state_nxt   = r_state;
        w_err_nxt     = r_err;
        w_len_nxt     = r_len;
        w_ack_exp_nxt = r_ack_exp;
        w_idx_nxt     = r_idx;
        w_count_nxt   = r_count;
        w_data_nxt    = r_data;
        w_done_nxt    = 1'b0;
        w_ack_nxt     = 1'b0;
        w_rd_en_nxt   = 1'b0;

        case (r_state)
            IDLE: begin
                if (bus.start) begin
                    w_len_nxt     = w_len_clamp;
                    w_ack_exp_nxt = bus.ack_expect;
                    w_idx_nxt     = '0;
                    w_count_nxt   = '0;
                    w_err_nxt     = NONE;
                    w_state_nxt   = (w_len_clamp == '0) ? DONE : RD_REQ;
                end
            end
            RD_REQ: begin
                if (!bus.fifo_empty) begin
                    w_rd_en_nxt = 1'b1;
                    w_state_nxt = RD_WAIT;
                end else if (w_expired) begin
                    w_err_nxt   = TIMEOUT;
                    w_state_nxt = DONE;
                end
            end
            // fifo_rd_en is high here; the FIFO presents the byte next cycle.
            RD_WAIT: w_state_nxt = CAPTURE;
            CAPTURE: begin
                if (r_ack_exp[r_idx] && (bus.fifo_data != UPDI_ACK_BYTE)) begin
                    w_err_nxt   = BAD_ACK;
                    w_state_nxt = DONE;
                end else begin
                    if (r_ack_exp[r_idx]) begin
                        w_ack_nxt = 1'b1;
                    end else begin
                        w_data_nxt[r_count[DATA_ADDR_BITS-1:0]] = bus.fifo_data;
                        w_count_nxt = r_count + LEN_W'(1);
                    end
                    if (w_last) begin
                        w_state_nxt = DONE;
                    end else begin
                        w_idx_nxt   = r_idx + DATA_ADDR_BITS'(1);
                        w_state_nxt = RD_REQ;
                    end
                end
            end
            DONE: begin
                w_done_nxt  = 1'b1;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase

        w_ready_nxt = (w_state_nxt == IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_err     <= NONE;
            r_len     <= '0;
            r_ack_exp <= '0;
            r_idx     <= '0;
            r_count   <= '0;
            r_data    <= '0;
            r_ready   <= 1'b0;
            r_done    <= 1'b0;
            r_ack     <= 1'b0;
            r_rd_en   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_err     <= w_err_nxt;
            r_len     <= w_len_nxt;
            r_ack_exp <= w_ack_exp_nxt;
            r_idx     <= w_idx_nxt;
            r_count   <= w_count_nxt;
            r_data    <= w_data_nxt;
            r_ready   <= w_ready_nxt;
            r_done    <= w_done_nxt;
            r_ack     <= w_ack_nxt;
            r_rd_en   <= w_rd_en_nxt;
        end
    end

    assign bus.ready        = r_ready;
    assign bus.done         = r_done;
    assign bus.ack_received = r_ack;
    assign bus.error_code   = r_err;
    assign bus.data         = r_data;
    assign bus.data_count   = r_count;
    assign bus.fifo_rd_en   = r_rd_en;
endmodule
